// File: rtl/fifo_pkg.sv
// Shared types and constants for the synchronous FIFO family used by the UART datapath.
package fifo_pkg;

    typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e;

    localparam int UART_TX_DATA_WIDTH = 8;
    localparam int UART_TX_FIFO_DEPTH = 16;
    localparam int UART_RX_DATA_WIDTH = 8;
    localparam int UART_RX_FIFO_DEPTH = 16;

    function automatic bit is_pow2(input int value);
        return (value >= 2) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage array for the FIFO: one synchronous write port, one asynchronous read port, no reset.
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_sync_flags.sv
// Synchronous FIFO with programmable almost-full/empty thresholds, sticky error flags,
// write-through-when-full and a per-instance choice of registered or first-word-fall-through read.
module fifo_sync_flags
    import fifo_pkg::*;
#(
    parameter int         DATA_WIDTH = 8,
    parameter int         FIFO_DEPTH = 16,
    parameter int         AF_THRESH  = 12,
    parameter int         AE_THRESH  = 4,
    parameter fifo_mode_e READ_MODE  = FIFO_STD,
    localparam int        ADDR_W     = $clog2(FIFO_DEPTH),
    localparam int        CNT_W      = ADDR_W + 1
) (
    input  logic                  clk,
    input  logic                  reset_b,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic [CNT_W-1:0]      data_count,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic                  overflow,
    output logic                  underflow
);

    if (!is_pow2(FIFO_DEPTH)) begin : g_depth_chk
        $error("fifo_sync_flags: FIFO_DEPTH must be a power of 2 and >= 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > FIFO_DEPTH) begin : g_af_chk
        $error("fifo_sync_flags: AF_THRESH must lie in 1..FIFO_DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > FIFO_DEPTH - 1) begin : g_ae_chk
        $error("fifo_sync_flags: AE_THRESH must lie in 0..FIFO_DEPTH-1");
    end

    logic [CNT_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  overflow_q;
    logic                  underflow_q;
    logic                  rd_acc;
    logic                  wr_acc;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    logic [CNT_W-1:0]      ptr_diff;

    assign empty        = (count == '0);
    assign full         = (count == CNT_W'(FIFO_DEPTH));
    assign almost_empty = (count <= CNT_W'(AE_THRESH));
    assign almost_full  = (count >= CNT_W'(AF_THRESH));
    assign data_count   = count;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // A full FIFO still takes a write when the same cycle frees a slot.
    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_en & (~full | rd_acc);

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (clear) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wr_en && !wr_acc) begin
                overflow_q <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADDR_WIDTH (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc & ~clear),
        .wr_addr (wr_ptr[ADDR_W-1:0]),
        .wr_data (data_in),
        .rd_addr (rd_ptr[ADDR_W-1:0]),
        .rd_data (mem_rd_data)
    );

    if (READ_MODE == FIFO_STD) begin : g_std
        logic [DATA_WIDTH-1:0] data_q;
        logic                  rd_valid_q;

        always_ff @(posedge clk or negedge reset_b) begin
            if (!reset_b) begin
                data_q     <= '0;
                rd_valid_q <= 1'b0;
            end else if (clear) begin
                data_q     <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_acc;
                if (rd_acc) begin
                    data_q <= mem_rd_data;
                end
            end
        end

        assign data_out = data_q;
        assign rd_valid = rd_valid_q;
    end else begin : g_fwft
        assign data_out = mem_rd_data;
        assign rd_valid = ~empty;
    end

    // The wrap bits make the pointer distance equal the occupancy, including when full.
    assign ptr_diff = wr_ptr - rd_ptr;

    a_ptr_count: assert property (@(posedge clk) disable iff (!reset_b) ptr_diff == count);

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Self-checking bench driving a registered-read and a FWFT instance with the same stimulus.
module tb_fifo_sync_flags;
    import fifo_pkg::*;

    localparam int DEPTH = 4;
    localparam int NVEC  = 19;

    logic       clk = 1'b0;
    logic       reset_b;
    logic       clear;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] data_in;

    logic [7:0] s_data_out, f_data_out;
    logic       s_rd_valid, f_rd_valid;
    logic [2:0] s_count, f_count;
    logic       s_empty, s_full, s_ae, s_af, s_ovf, s_udf;
    logic       f_empty, f_full, f_ae, f_af, f_ovf, f_udf;

    typedef struct {
        logic       wr;
        logic       rd;
        logic       clr;
        logic [7:0] din;
        logic [2:0] cnt;
        logic [5:0] flags;
    } vec_t;

    vec_t       vecs [NVEC];
    logic [7:0] q_std [$];
    logic [7:0] q_fw  [$];
    int         checks   = 0;
    int         failures = 0;
    int         prev_cnt = 0;
    logic       exp_s_valid;

    always #5 clk = ~clk;

    fifo_sync_flags #(
        .DATA_WIDTH (8), .FIFO_DEPTH (DEPTH), .AF_THRESH (3), .AE_THRESH (1), .READ_MODE (FIFO_STD)
    ) u_std (
        .clk (clk), .reset_b (reset_b), .clear (clear), .wr_en (wr_en), .data_in (data_in),
        .rd_en (rd_en), .data_out (s_data_out), .rd_valid (s_rd_valid), .data_count (s_count),
        .empty (s_empty), .full (s_full), .almost_empty (s_ae), .almost_full (s_af),
        .overflow (s_ovf), .underflow (s_udf)
    );

    fifo_sync_flags #(
        .DATA_WIDTH (8), .FIFO_DEPTH (DEPTH), .AF_THRESH (3), .AE_THRESH (1), .READ_MODE (FIFO_FWFT)
    ) u_fwft (
        .clk (clk), .reset_b (reset_b), .clear (clear), .wr_en (wr_en), .data_in (data_in),
        .rd_en (rd_en), .data_out (f_data_out), .rd_valid (f_rd_valid), .data_count (f_count),
        .empty (f_empty), .full (f_full), .almost_empty (f_ae), .almost_full (f_af),
        .overflow (f_ovf), .underflow (f_udf)
    );

    function automatic vec_t mk(logic wr, logic rd, logic clr, logic [7:0] din,
                                logic [2:0] cnt, logic [5:0] flags);
        vec_t v;
        v.wr = wr; v.rd = rd; v.clr = clr; v.din = din; v.cnt = cnt; v.flags = flags;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Flags are packed as {full, empty, almost_full, almost_empty, overflow, underflow}.
    task automatic check_reset_values(input string tag);
        check({tag, " std count"}, 32'(s_count), 0);
        check({tag, " fwft count"}, 32'(f_count), 0);
        check({tag, " std flags"}, 32'({s_full, s_empty, s_af, s_ae, s_ovf, s_udf}), 32'b010100);
        check({tag, " fwft flags"}, 32'({f_full, f_empty, f_af, f_ae, f_ovf, f_udf}), 32'b010100);
        check({tag, " std data_out"}, 32'(s_data_out), 0);
        check({tag, " std rd_valid"}, 32'(s_rd_valid), 0);
        check({tag, " fwft rd_valid"}, 32'(f_rd_valid), 0);
    endtask

    task automatic apply_stimulus(input vec_t v);
        logic rd_acc, wr_acc;
        rd_acc = v.rd && (prev_cnt != 0) && !v.clr;
        wr_acc = v.wr && ((prev_cnt != DEPTH) || rd_acc) && !v.clr;
        wr_en   = v.wr;
        rd_en   = v.rd;
        clear   = v.clr;
        data_in = v.din;
        if (wr_acc) begin
            q_std.push_back(v.din);
            q_fw.push_back(v.din);
        end
        @(posedge clk);
        #1;
        if (v.clr) begin
            q_std.delete();
            q_fw.delete();
        end else if (rd_acc && q_fw.size() > 0) begin
            void'(q_fw.pop_front());
        end
        exp_s_valid = rd_acc;
        prev_cnt    = int'(v.cnt);
    endtask

    task automatic check_output(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        check({tag, " std count"}, 32'(s_count), 32'(v.cnt));
        check({tag, " fwft count"}, 32'(f_count), 32'(v.cnt));
        check({tag, " std flags"}, 32'({s_full, s_empty, s_af, s_ae, s_ovf, s_udf}), 32'(v.flags));
        check({tag, " fwft flags"}, 32'({f_full, f_empty, f_af, f_ae, f_ovf, f_udf}), 32'(v.flags));
        check({tag, " std rd_valid"}, 32'(s_rd_valid), 32'(exp_s_valid));
        check({tag, " fwft rd_valid"}, 32'(f_rd_valid), 32'(!v.flags[4]));
        if (s_rd_valid) begin
            if (q_std.size() == 0) begin
                check({tag, " std scoreboard nonempty"}, 0, 1);
            end else begin
                check({tag, " std data_out"}, 32'(s_data_out), 32'(q_std.pop_front()));
            end
        end
        if (!v.flags[4]) begin
            if (q_fw.size() == 0) begin
                check({tag, " fwft scoreboard nonempty"}, 0, 1);
            end else begin
                check({tag, " fwft head"}, 32'(f_data_out), 32'(q_fw[0]));
            end
        end
        if (v.clr) begin
            check({tag, " std data_out cleared"}, 32'(s_data_out), 0);
        end
    endtask

    initial begin
        vecs[0]  = mk(1, 0, 0, 8'hA1, 1, 6'b000100);
        vecs[1]  = mk(1, 0, 0, 8'hA2, 2, 6'b000000);
        vecs[2]  = mk(0, 1, 0, 8'h00, 1, 6'b000100);
        vecs[3]  = mk(0, 1, 0, 8'h00, 0, 6'b010100);
        vecs[4]  = mk(1, 0, 0, 8'hB0, 1, 6'b000100);
        vecs[5]  = mk(1, 0, 0, 8'hB1, 2, 6'b000000);
        vecs[6]  = mk(1, 0, 0, 8'hB2, 3, 6'b001000);
        vecs[7]  = mk(1, 0, 0, 8'hB3, 4, 6'b101000);
        vecs[8]  = mk(1, 1, 0, 8'h55, 4, 6'b101000);
        vecs[9]  = mk(1, 0, 0, 8'hB4, 4, 6'b101010);
        vecs[10] = mk(0, 1, 0, 8'h00, 3, 6'b001010);
        vecs[11] = mk(0, 1, 0, 8'h00, 2, 6'b000010);
        vecs[12] = mk(0, 1, 0, 8'h00, 1, 6'b000110);
        vecs[13] = mk(0, 1, 0, 8'h00, 0, 6'b010110);
        vecs[14] = mk(0, 1, 0, 8'h00, 0, 6'b010111);
        vecs[15] = mk(1, 1, 0, 8'h77, 1, 6'b000111);
        vecs[16] = mk(1, 0, 0, 8'h78, 2, 6'b000011);
        vecs[17] = mk(1, 0, 0, 8'h79, 3, 6'b001011);
        vecs[18] = mk(1, 1, 1, 8'hEE, 0, 6'b010100);

        reset_b = 1'b0;
        clear   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        data_in = 8'h00;
        exp_s_valid = 1'b0;
        #12;
        check_reset_values("reset");
        @(negedge clk);
        reset_b = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            apply_stimulus(vecs[i]);
            check_output(vecs[i], i);
        end

        // FWFT head becomes visible the cycle after the write, without any rd_en.
        wr_en = 1'b1; rd_en = 1'b0; clear = 1'b0; data_in = 8'h3C;
        @(posedge clk); #1;
        wr_en = 1'b0;
        check("fwft head after write", 32'(f_data_out), 32'h3C);
        check("fwft rd_valid after write", 32'(f_rd_valid), 1);
        check("std rd_valid idle", 32'(s_rd_valid), 0);
        @(posedge clk); #1;
        check("fwft head holds", 32'(f_data_out), 32'h3C);
        rd_en = 1'b1;
        @(posedge clk); #1;
        rd_en = 1'b0;
        check("fwft empty after pop", 32'(f_empty), 1);
        check("fwft rd_valid after pop", 32'(f_rd_valid), 0);
        check("std rd_valid after pop", 32'(s_rd_valid), 1);
        check("std data after pop", 32'(s_data_out), 32'h3C);
        @(posedge clk); #1;
        check("std rd_valid one cycle", 32'(s_rd_valid), 0);
        check("std data_out holds", 32'(s_data_out), 32'h3C);

        // Asynchronous reset arriving mid-write, away from any clock edge.
        wr_en = 1'b1; data_in = 8'hAA;
        @(posedge clk); #1;
        check("count before async reset", 32'(s_count), 1);
        #2;
        reset_b = 1'b0;
        #1;
        check_reset_values("async reset");
        wr_en = 1'b0;
        @(negedge clk);
        reset_b = 1'b1;
        wr_en = 1'b1; data_in = 8'h11;
        @(posedge clk); #1;
        wr_en = 1'b0;
        check("count after recovery", 32'(f_count), 1);
        check("fwft head after recovery", 32'(f_data_out), 32'h11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
